// File: rtl/alu_req_scheduler_pkg.sv
// Shared constants and opcode encoding for the ALU request scheduler.
// Tag layout on the ALU sideband is {seq, requester id}.
package alu_req_scheduler_pkg;

  localparam int WIDTH    = 32;
  localparam int DATABITS = 7;
  localparam int NREQ     = 4;
  localparam int ID_BITS  = 2;
  localparam int SEQ_BITS = 5;
  localparam int MAX_OUT  = 4;
  localparam int CNT_BITS = 3;

  localparam int TAG_ID_LSB  = 0;
  localparam int TAG_SEQ_LSB = ID_BITS;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_MULT = 2'd3
  } alu_op_e;

endpackage

// File: rtl/alu_req_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first eligible
// requester after last_grant.
module alu_req_scheduler_rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   eligible,
  input  logic [IDW-1:0] last_grant,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           any
);

  logic [IDW-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDW'((int'(last_grant) + k) % N);
      if (!any && eligible[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one pipelined ALU between NREQ requesters, tags ops with
// {seq, id} and routes results back by tag.
module alu_req_scheduler
  import alu_req_scheduler_pkg::*;
#(
  parameter int P_WIDTH    = WIDTH,
  parameter int P_DATABITS = DATABITS,
  parameter int P_NREQ     = NREQ,
  parameter int P_ID_BITS  = ID_BITS,
  parameter int P_SEQ_BITS = SEQ_BITS,
  parameter int P_MAX_OUT  = MAX_OUT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [P_NREQ-1:0]          req_valid,
  output logic [P_NREQ-1:0]          req_ready,
  input  logic [P_NREQ*P_WIDTH-1:0]  req_a,
  input  logic [P_NREQ*P_WIDTH-1:0]  req_b,
  input  logic [P_NREQ*2-1:0]        req_op,
  output logic [P_NREQ-1:0]          rsp_valid,
  output logic [P_WIDTH-1:0]         rsp_res,
  output logic [1:0]                 rsp_op,
  output logic [P_SEQ_BITS-1:0]      rsp_seq,
  output logic                       tag_err,
  output logic [P_WIDTH-1:0]         alu_a,
  output logic [P_WIDTH-1:0]         alu_b,
  output logic [1:0]                 alu_op,
  output logic [P_DATABITS-1:0]      alu_databits,
  input  logic [P_WIDTH-1:0]         alu_res,
  input  logic [1:0]                 alu_out_op,
  input  logic [P_DATABITS-1:0]      alu_out_databits
);

  logic [P_WIDTH-1:0]    a_arr [P_NREQ];
  logic [P_WIDTH-1:0]    b_arr [P_NREQ];
  logic [1:0]            op_arr [P_NREQ];
  logic [CNT_BITS-1:0]   outstanding [P_NREQ];
  logic [P_SEQ_BITS-1:0] seq [P_NREQ];
  logic [P_ID_BITS-1:0]  last_grant;

  logic [P_NREQ-1:0]     eligible;
  logic [P_NREQ-1:0]     grant;
  logic [P_ID_BITS-1:0]  gid;
  logic                  any;
  logic                  issue_live;
  logic                  ret_live;
  logic                  ret_ok;
  logic [P_ID_BITS-1:0]  ret_id;
  logic [P_SEQ_BITS-1:0] ret_seq;

  for (genvar g = 0; g < P_NREQ; g++) begin : g_unpack
    assign a_arr[g]  = req_a[g*P_WIDTH +: P_WIDTH];
    assign b_arr[g]  = req_b[g*P_WIDTH +: P_WIDTH];
    assign op_arr[g] = req_op[g*2 +: 2];
  end

  always_comb begin
    eligible = '0;
    for (int i = 0; i < P_NREQ; i++) begin
      eligible[i] = !reset && req_valid[i] &&
        (outstanding[i] < CNT_BITS'(P_MAX_OUT));
    end
  end

  alu_req_scheduler_rr_arbiter #(
    .N   (P_NREQ),
    .IDW (P_ID_BITS)
  ) u_arb (
    .eligible   (eligible),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_id   (gid),
    .any        (any)
  );

  assign req_ready  = grant;
  assign issue_live = any && (op_arr[gid] != OP_NOP);
  assign ret_live   = (alu_out_op != OP_NOP);
  assign ret_id     = alu_out_databits[TAG_ID_LSB +: P_ID_BITS];
  assign ret_seq    = alu_out_databits[P_ID_BITS +: P_SEQ_BITS];
  assign ret_ok     = ret_live && (outstanding[ret_id] != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= OP_NOP;
      alu_databits <= '0;
      rsp_valid    <= '0;
      rsp_res      <= '0;
      rsp_op       <= OP_NOP;
      rsp_seq      <= '0;
      tag_err      <= 1'b0;
      // Pointer at the last slot so requester 0 has first priority
      last_grant   <= P_ID_BITS'(P_NREQ - 1);
      for (int i = 0; i < P_NREQ; i++) begin
        outstanding[i] <= '0;
        seq[i]         <= '0;
      end
    end else begin
      alu_op <= any ? op_arr[gid] : OP_NOP;
      if (any) begin
        alu_a        <= a_arr[gid];
        alu_b        <= b_arr[gid];
        alu_databits <= {seq[gid], gid};
        last_grant   <= gid;
      end
      if (issue_live) begin
        seq[gid] <= seq[gid] + P_SEQ_BITS'(1);
      end
      for (int i = 0; i < P_NREQ; i++) begin
        unique case ({issue_live && (gid == P_ID_BITS'(i)),
                      ret_ok && (ret_id == P_ID_BITS'(i))})
          2'b10:   outstanding[i] <= outstanding[i] + CNT_BITS'(1);
          2'b01:   outstanding[i] <= outstanding[i] - CNT_BITS'(1);
          default: outstanding[i] <= outstanding[i];
        endcase
      end
      rsp_valid <= ret_ok ? (P_NREQ'(1) << ret_id) : '0;
      if (ret_ok) begin
        rsp_res <= alu_res;
        rsp_op  <= alu_out_op;
        rsp_seq <= ret_seq;
      end
      if (ret_live && !ret_ok) begin
        tag_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler with a queued in-order ALU model
// that can be stalled, single-stepped or overridden.
module tb_alu_req_scheduler;
  import alu_req_scheduler_pkg::*;

  localparam int W  = 32;
  localparam int DB = 7;
  localparam int N  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N*2-1:0]   req_op;
  logic [N-1:0]     rsp_valid;
  logic [W-1:0]     rsp_res;
  logic [1:0]       rsp_op;
  logic [4:0]       rsp_seq;
  logic             tag_err;
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic [1:0]       alu_op;
  logic [DB-1:0]    alu_databits;
  logic [W-1:0]     alu_res;
  logic [1:0]       alu_out_op;
  logic [DB-1:0]    alu_out_databits;

  always #5 clk = ~clk;

  alu_req_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_a            (req_a),
    .req_b            (req_b),
    .req_op           (req_op),
    .rsp_valid        (rsp_valid),
    .rsp_res          (rsp_res),
    .rsp_op           (rsp_op),
    .rsp_seq          (rsp_seq),
    .tag_err          (tag_err),
    .alu_a            (alu_a),
    .alu_b            (alu_b),
    .alu_op           (alu_op),
    .alu_databits     (alu_databits),
    .alu_res          (alu_res),
    .alu_out_op       (alu_out_op),
    .alu_out_databits (alu_out_databits)
  );

  typedef struct {
    logic [W-1:0]  res;
    logic [1:0]    op;
    logic [DB-1:0] tag;
  } item_t;

  item_t         aq[$];
  item_t         dump;
  logic [W-1:0]  p_res;
  logic [1:0]    p_op;
  logic [DB-1:0] p_tag;
  logic          drain_en;
  logic          force_en;
  logic [W-1:0]  f_res;
  logic [1:0]    f_op;
  logic [DB-1:0] f_tag;

  function automatic logic [W-1:0] calc(logic [1:0] op,
                                        logic [W-1:0] a,
                                        logic [W-1:0] b);
    case (op)
      2'd1:    return a + b;
      2'd2:    return a - b;
      2'd3:    return a * b;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      aq.delete();
      p_op  <= 2'd0;
      p_res <= '0;
      p_tag <= '0;
    end else begin
      if (drain_en && aq.size() > 0) begin
        p_res <= aq[0].res;
        p_op  <= aq[0].op;
        p_tag <= aq[0].tag;
        dump = aq.pop_front();
      end else begin
        p_op <= 2'd0;
      end
      if (alu_op != 2'd0)
        aq.push_back('{calc(alu_op, alu_a, alu_b), alu_op, alu_databits});
    end
  end

  assign alu_res          = force_en ? f_res : p_res;
  assign alu_out_op       = force_en ? f_op  : p_op;
  assign alu_out_databits = force_en ? f_tag : p_tag;

  typedef struct {
    int           id;
    logic [W-1:0] res;
    logic [1:0]   op;
    logic [4:0]   seq;
  } rsp_t;

  rsp_t rlog[$];

  always @(negedge clk) begin
    if (!reset)
      for (int i = 0; i < N; i++)
        if (rsp_valid[i]) rlog.push_back('{i, rsp_res, rsp_op, rsp_seq});
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int id, logic [1:0] op,
                         logic [W-1:0] a, logic [W-1:0] b);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_op[id*2 +: 2] = op;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    int           id;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [4:0]   seq;
  } vec_t;

  vec_t tbl[6];
  int   exp3[10];
  int   cnt[N];
  int   n;
  int   acc;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 2'd1, 32'd5,          32'd7,       32'd12,         5'd0};
    tbl[1] = '{1, 2'd2, 32'd3,          32'd5,       32'hFFFFFFFE,   5'd0};
    tbl[2] = '{2, 2'd3, 32'd6,          32'd7,       32'd42,         5'd0};
    tbl[3] = '{0, 2'd1, 32'hFFFFFFFF,   32'd1,       32'd0,          5'd1};
    tbl[4] = '{3, 2'd3, 32'h00010000,   32'h00010000, 32'd0,         5'd0};
    tbl[5] = '{1, 2'd1, 32'd100,        32'd23,      32'd123,        5'd1};
    exp3 = '{1, 4, 1, 4, 1, 4, 1, 4, 1, 1};

    reset = 1'b1;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    drain_en = 1'b1;
    force_en = 1'b0;
    f_res = '0;
    f_op = 2'd0;
    f_tag = '0;
    tick();
    tick();
    chk("rst_ready",    32'(req_ready), 32'd0);
    chk("rst_alu_op",   32'(alu_op), 32'd0);
    chk("rst_rsp",      32'(rsp_valid), 32'd0);
    chk("rst_tag_err",  32'(tag_err), 32'd0);
    chk("rst_alu_tag",  32'(alu_databits), 32'd0);
    req_valid = '0;
    reset = 1'b0;

    // Single-op vectors, one requester at a time
    for (int v = 0; v < 6; v++) begin
      set_req(tbl[v].id, tbl[v].op, tbl[v].a, tbl[v].b);
      req_valid = N'(1) << tbl[v].id;
      #1;
      chk("t1_ready", 32'(req_ready), 32'(1 << tbl[v].id));
      tick();
      req_valid = '0;
      chk("t1_alu_op", 32'(alu_op), 32'(tbl[v].op));
      chk("t1_alu_a", alu_a, tbl[v].a);
      chk("t1_alu_tag", 32'(alu_databits),
          32'({tbl[v].seq, 2'(tbl[v].id)}));
      n = 0;
      while (alu_out_op == 2'd0 && n < 10) begin
        tick();
        n++;
      end
      chk("t1_alu_out_timeout", 32'(n < 10), 32'd1);
      chk("t1_rsp_early", 32'(rsp_valid), 32'd0);
      tick();
      chk("t1_rsp_valid", 32'(rsp_valid), 32'(1 << tbl[v].id));
      chk("t1_rsp_res", rsp_res, tbl[v].res);
      chk("t1_rsp_op", 32'(rsp_op), 32'(tbl[v].op));
      chk("t1_rsp_seq", 32'(rsp_seq), 32'(tbl[v].seq));
      tick();
      chk("t1_rsp_pulse", 32'(rsp_valid), 32'd0);
    end

    // All four requesters valid continuously
    do_reset();
    rlog.delete();
    drain_en = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 2'd1, W'(i + 1), 32'd10);
    req_valid = '1;
    for (int c = 0; c < 16; c++) begin
      #1;
      chk("t2_grant", 32'(req_ready), 32'(1 << (c % 4)));
      tick();
    end
    req_valid = '0;
    repeat (10) tick();
    chk("t2_rsp_count", 32'(rlog.size()), 32'd16);
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int k = 0; k < rlog.size(); k++) begin
      chk("t2_seq", 32'(rlog[k].seq), 32'(cnt[rlog[k].id]));
      chk("t2_res", rlog[k].res, 32'(rlog[k].id + 11));
      cnt[rlog[k].id]++;
    end
    for (int i = 0; i < N; i++) chk("t2_per_req", 32'(cnt[i]), 32'd4);

    // Outstanding cap on req2 while req0 keeps winning with NOPs
    drain_en = 1'b0;
    do_reset();
    rlog.delete();
    set_req(0, 2'd0, 32'd0, 32'd0);
    set_req(2, 2'd1, 32'd20, 32'd22);
    req_valid = 4'b0101;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("t3_grant", 32'(req_ready), 32'(exp3[c]));
      tick();
    end
    drain_en = 1'b1;
    tick();
    drain_en = 1'b0;
    #1;
    chk("t3_still_capped", 32'(req_ready), 32'd1);
    tick();
    chk("t3_retire_rsp", 32'(rsp_valid), 32'd4);
    #1;
    chk("t3_reenabled", 32'(req_ready), 32'd4);
    tick();
    req_valid = '0;
    drain_en = 1'b1;
    repeat (14) tick();
    chk("t3_rsp_count", 32'(rlog.size()), 32'd5);
    for (int k = 0; k < rlog.size(); k++) begin
      chk("t3_id", 32'(rlog[k].id), 32'd2);
      chk("t3_seq", 32'(rlog[k].seq), 32'(k));
      chk("t3_res", rlog[k].res, 32'd42);
    end

    // Sequence wrap on req1
    do_reset();
    rlog.delete();
    drain_en = 1'b1;
    set_req(1, 2'd2, 32'd3, 32'd5);
    acc = 0;
    for (int c = 0; c < 200 && acc < 33; c++) begin
      req_valid = 4'b0010;
      #1;
      if (req_ready[1]) acc++;
      tick();
    end
    req_valid = '0;
    chk("t4_accepts", 32'(acc), 32'd33);
    repeat (12) tick();
    chk("t4_rsp_count", 32'(rlog.size()), 32'd33);
    for (int k = 0; k < rlog.size(); k++) begin
      chk("t4_seq", 32'(rlog[k].seq), 32'(k % 32));
      chk("t4_res", rlog[k].res, 32'hFFFFFFFE);
      chk("t4_op", 32'(rlog[k].op), 32'd2);
    end

    // Same-cycle issue and retire on req0 at three outstanding
    drain_en = 1'b0;
    do_reset();
    rlog.delete();
    set_req(0, 2'd1, 32'd5, 32'd7);
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'b0001;
      #1;
      chk("t5_fill", 32'(req_ready), 32'd1);
      tick();
    end
    req_valid = '0;
    drain_en = 1'b1;
    tick();
    drain_en = 1'b0;
    req_valid = 4'b0001;
    #1;
    chk("t5_no_stall", 32'(req_ready), 32'd1);
    tick();
    chk("t5_rsp", 32'(rsp_valid), 32'd1);
    chk("t5_tag_err", 32'(tag_err), 32'd0);
    #1;
    chk("t5_cnt_is_3", 32'(req_ready), 32'd1);
    tick();
    #1;
    chk("t5_cnt_is_4", 32'(req_ready), 32'd0);
    req_valid = '0;
    drain_en = 1'b1;
    repeat (12) tick();
    chk("t5_rsp_count", 32'(rlog.size()), 32'd5);
    for (int k = 0; k < rlog.size(); k++)
      chk("t5_seq", 32'(rlog[k].seq), 32'(k));
    chk("t5_tag_err_end", 32'(tag_err), 32'd0);

    // Reset with ops in flight, then a stray tagged result
    rlog.delete();
    drain_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'b0001;
      #1;
      tick();
    end
    reset = 1'b1;
    tick();
    chk("t6_alu_op", 32'(alu_op), 32'd0);
    chk("t6_alu_a", alu_a, 32'd0);
    chk("t6_alu_tag", 32'(alu_databits), 32'd0);
    chk("t6_rsp", 32'(rsp_valid), 32'd0);
    chk("t6_rsp_res", rsp_res, 32'd0);
    chk("t6_ready", 32'(req_ready), 32'd0);
    chk("t6_tag_err", 32'(tag_err), 32'd0);
    reset = 1'b0;
    req_valid = '0;
    drain_en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("t6_no_stray", 32'(rsp_valid), 32'd0);
    end
    chk("t6_log_empty", 32'(rlog.size()), 32'd0);
    chk("t6_tag_err_clean", 32'(tag_err), 32'd0);
    force_en = 1'b1;
    f_op = 2'd1;
    f_tag = 7'd1;
    f_res = 32'd99;
    tick();
    force_en = 1'b0;
    chk("t6_tag_err_set", 32'(tag_err), 32'd1);
    chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
    tick();
    tick();
    chk("t6_tag_err_sticky", 32'(tag_err), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
